// File: rtl/cmov_write.sv
`default_nettype none
// cmov_write: copies region A (sel=1) or region B (sel=0) word by word into a destination region.
// Build option CMOV_CONSTTIME_EN: read both regions for every word and merge with a sel mask.
module cmov_write #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sel,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] src_a_base,
   input  logic [ADDR_W-1:0] src_b_base,
   input  logic [ADDR_W-1:0] dst_base,
   output logic [ADDR_W-1:0] rd_address,
   output logic              rd_en,
   input  logic [DATA_W-1:0] din,
   output logic [ADDR_W-1:0] wr_address,
   output logic              wr_en,
   output logic [DATA_W-1:0] dout,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d, rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [ADDR_W-1:0] dst_q, dst_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rvalid_q;   // din carries the word requested last cycle
   logic              last_rd;

`ifdef CMOV_CONSTTIME_EN
   logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d;
   logic              sel_q, sel_d, ph_q, ph_d, rph_q;
   logic [DATA_W-1:0] a_word_q, a_word_d, mask;
`else
   logic [ADDR_W-1:0] src_q, src_d;
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rd_idx_d  = rd_idx_q;
      wr_idx_d  = wr_idx_q;
      dst_d     = dst_q;
      rd_addr_d = rd_addr_q;
      rd_en_d   = rd_en_q;
      wr_addr_d = wr_addr_q;
      wr_en_d   = 1'b0;
      dout_d    = dout_q;
`ifdef CMOV_CONSTTIME_EN
      a_base_d  = a_base_q;
      b_base_d  = b_base_q;
      sel_d     = sel_q;
      ph_d      = ph_q;
      a_word_d  = a_word_q;
      mask      = {DATA_W{sel_q}};
      last_rd   = ph_q && (rd_idx_q == len_q - LEN_W'(1));
`else
      src_d     = src_q;
      last_rd   = (rd_idx_q == len_q - LEN_W'(1));
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_d    = len;
               dst_d    = dst_base;
               rd_idx_d = '0;
               wr_idx_d = '0;
`ifdef CMOV_CONSTTIME_EN
               a_base_d = src_a_base;
               b_base_d = src_b_base;
               sel_d    = sel;
               ph_d     = 1'b0;
`else
               src_d    = sel ? src_a_base : src_b_base;
`endif
               if (len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
                  rd_en_d = 1'b1;
`ifdef CMOV_CONSTTIME_EN
                  rd_addr_d = src_a_base;
`else
                  rd_addr_d = src_d;
`endif
               end
            end
         end
         S_READ: begin
            if (last_rd) begin
               state_d = S_DRAIN;
               rd_en_d = 1'b0;
            end else begin
`ifdef CMOV_CONSTTIME_EN
               // A then B for each index; the pattern never depends on sel
               if (!ph_q) begin
                  ph_d      = 1'b1;
                  rd_addr_d = b_base_q + ADDR_W'(rd_idx_q);
               end else begin
                  ph_d      = 1'b0;
                  rd_idx_d  = rd_idx_q + LEN_W'(1);
                  rd_addr_d = a_base_q + ADDR_W'(rd_idx_d);
               end
`else
               rd_idx_d  = rd_idx_q + LEN_W'(1);
               rd_addr_d = src_q + ADDR_W'(rd_idx_d);
`endif
            end
         end
         S_DRAIN: begin
            if (!rvalid_q) state_d = S_DONE;
         end
         default: ;
      endcase

`ifdef CMOV_CONSTTIME_EN
      if (rvalid_q && !rph_q) a_word_d = din;
      if (rvalid_q && rph_q) begin
         dout_d    = (a_word_q & mask) | (din & ~mask);
         wr_en_d   = 1'b1;
         wr_addr_d = dst_q + ADDR_W'(wr_idx_q);
         wr_idx_d  = wr_idx_q + LEN_W'(1);
      end
`else
      if (rvalid_q) begin
         dout_d    = din;
         wr_en_d   = 1'b1;
         wr_addr_d = dst_q + ADDR_W'(wr_idx_q);
         wr_idx_d  = wr_idx_q + LEN_W'(1);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         rd_idx_q  <= '0;
         wr_idx_q  <= '0;
         dst_q     <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_en_q   <= 1'b0;
         dout_q    <= '0;
         rvalid_q  <= 1'b0;
`ifdef CMOV_CONSTTIME_EN
         a_base_q  <= '0;
         b_base_q  <= '0;
         sel_q     <= 1'b0;
         ph_q      <= 1'b0;
         rph_q     <= 1'b0;
         a_word_q  <= '0;
`else
         src_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         rd_idx_q  <= rd_idx_d;
         wr_idx_q  <= wr_idx_d;
         dst_q     <= dst_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         wr_addr_q <= wr_addr_d;
         wr_en_q   <= wr_en_d;
         dout_q    <= dout_d;
         rvalid_q  <= rd_en_q;
`ifdef CMOV_CONSTTIME_EN
         a_base_q  <= a_base_d;
         b_base_q  <= b_base_d;
         sel_q     <= sel_d;
         ph_q      <= ph_d;
         rph_q     <= ph_q;
         a_word_q  <= a_word_d;
`else
         src_q     <= src_d;
`endif
      end
   end

   assign rd_address = rd_addr_q;
   assign rd_en      = rd_en_q;
   assign wr_address = wr_addr_q;
   assign wr_en      = wr_en_q;
   assign dout       = dout_q;
   assign busy       = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cmov_write.sv
`default_nettype none
// tb_cmov_write: directed and randomized transfers checked against a queue-based reference model.
module tb_cmov_write;
   localparam int AW = 9;
   localparam int DW = 64;
   localparam int LW = 10;

   logic          clk = 1'b0, rst = 1'b0, start = 1'b0, sel = 1'b0;
   logic [LW-1:0] len = '0;
   logic [AW-1:0] src_a_base = '0, src_b_base = '0, dst_base = '0;
   logic [AW-1:0] rd_address, wr_address;
   logic          rd_en, wr_en, busy, done;
   logic [DW-1:0] din = '0, dout;

   logic [DW-1:0] mem [0:511];
   logic [AW-1:0] rd_log[$], wa_log[$], exp_rd[$], exp_wa[$];
   logic [DW-1:0] wd_log[$], exp_wd[$];
   int obs_done, obs_busy, exp_done, exp_busy;
   int n_cmp = 0, n_err = 0;

   cmov_write #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel), .len(len),
      .src_a_base(src_a_base), .src_b_base(src_b_base), .dst_base(dst_base),
      .rd_address(rd_address), .rd_en(rd_en), .din(din),
      .wr_address(wr_address), .wr_en(wr_en), .dout(dout),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // synchronous-read memory: data one cycle after the request
   always @(posedge clk) if (rd_en) din <= mem[rd_address];

   // reference: selected region copied to dst, reads/cycles as the access scheme dictates
   function automatic void build_expect(input logic s, input int n,
                                        input logic [AW-1:0] a, input logic [AW-1:0] b,
                                        input logic [AW-1:0] d);
      int per_word;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
`ifdef CMOV_CONSTTIME_EN
      per_word = 2;
`else
      per_word = 1;
`endif
      for (int k = 0; k < n; k++) begin
`ifdef CMOV_CONSTTIME_EN
         exp_rd.push_back(AW'(a + k));
         exp_rd.push_back(AW'(b + k));
`else
         exp_rd.push_back(s ? AW'(a + k) : AW'(b + k));
`endif
         exp_wa.push_back(AW'(d + k));
         exp_wd.push_back(s ? mem[AW'(a + k)] : mem[AW'(b + k)]);
      end
      exp_done = (n == 0) ? 1 : per_word * n + 3;
      exp_busy = (n == 0) ? 0 : per_word * n + 2;
   endfunction

   // start at cycle 0, observe every cycle until done; optionally inject a start or a reset
   task automatic run_xfer(input logic s, input int n, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input int inj, input int abort_w);
      int cyc;
      rd_log.delete(); wa_log.delete(); wd_log.delete();
      obs_done = -1; obs_busy = 0;
      @(negedge clk);
      sel = s; len = LW'(n); src_a_base = a; src_b_base = b; dst_base = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc <= 2 * n + 20) begin
         if (rd_en) rd_log.push_back(rd_address);
         if (wr_en) begin wa_log.push_back(wr_address); wd_log.push_back(dout); end
         if (busy) obs_busy++;
         if (done) begin obs_done = cyc; break; end
         if (abort_w >= 0 && wa_log.size() == abort_w) begin rst = 1'b0; break; end
         if (cyc == inj) begin
            start = 1'b1; sel = ~s; len = LW'(3);
            src_a_base = b; src_b_base = a; dst_base = d + 9'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rd_en, wr_en, busy, done} !== 4'b0) begin
         n_err++; $display("FAIL reset_strobes: got %b expected 0000", {rd_en, wr_en, busy, done});
      end
      n_cmp++;
      if ({rd_address, wr_address, dout} !== '0) begin
         n_err++; $display("FAIL reset_regs: got %h/%h/%h expected 0", rd_address, wr_address, dout);
      end
      rst = 1'b1;
   endtask

   task automatic test_copy(input string name, input logic s, input int n, input logic [AW-1:0] a,
                            input logic [AW-1:0] b, input logic [AW-1:0] d, input int inj);
      build_expect(s, n, a, b, d);
      run_xfer(s, n, a, b, d, inj, -1);
      n_cmp++;
      if (obs_done !== exp_done) begin
         n_err++; $display("FAIL %s done_cycle: got %0d expected %0d", name, obs_done, exp_done);
      end
      n_cmp++;
      if (obs_busy !== exp_busy) begin
         n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, obs_busy, exp_busy);
      end
      n_cmp++;
      if (rd_log.size() !== exp_rd.size()) begin
         n_err++; $display("FAIL %s read_count: got %0d expected %0d", name, rd_log.size(), exp_rd.size());
      end
      for (int k = 0; k < rd_log.size() && k < exp_rd.size(); k++) begin
         n_cmp++;
         if (rd_log[k] !== exp_rd[k]) begin
            n_err++; $display("FAIL %s rd_addr[%0d]: got %h expected %h", name, k, rd_log[k], exp_rd[k]);
         end
      end
      n_cmp++;
      if (wa_log.size() !== exp_wa.size()) begin
         n_err++; $display("FAIL %s write_count: got %0d expected %0d", name, wa_log.size(), exp_wa.size());
      end
      for (int k = 0; k < wa_log.size() && k < exp_wa.size(); k++) begin
         n_cmp++;
         if (wa_log[k] !== exp_wa[k] || wd_log[k] !== exp_wd[k]) begin
            n_err++;
            $display("FAIL %s write[%0d]: got %h<=%h expected %h<=%h",
                     name, k, wa_log[k], wd_log[k], exp_wa[k], exp_wd[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      build_expect(1'b1, 8, 9'h100, 9'h120, 9'h040);
      run_xfer(1'b1, 8, 9'h100, 9'h120, 9'h040, -1, 3);
      #1;
      n_cmp++;
      if ({rd_en, wr_en, busy, done, rd_address, wr_address, dout} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got en=%b%b%b%b ra=%h wa=%h d=%h expected all 0",
                  rd_en, wr_en, busy, done, rd_address, wr_address, dout);
      end
      repeat (4) begin
         @(negedge clk);
         if (wr_en) begin wa_log.push_back(wr_address); wd_log.push_back(dout); end
      end
      n_cmp++;
      if (wa_log.size() !== 3) begin
         n_err++; $display("FAIL reset_mid_writes: got %0d expected 3", wa_log.size());
      end
      for (int k = 0; k < 3 && k < wa_log.size(); k++) begin
         n_cmp++;
         if (wa_log[k] !== exp_wa[k] || wd_log[k] !== exp_wd[k]) begin
            n_err++; $display("FAIL reset_mid_write[%0d]: got %h<=%h expected %h<=%h",
                              k, wa_log[k], wd_log[k], exp_wa[k], exp_wd[k]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      test_copy("after_reset", 1'b0, 8, 9'h100, 9'h120, 9'h040, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
      for (int t = 0; t < 10; t++) begin
         logic [AW-1:0] a, b, d;
         a = (t == 0) ? 9'h1FC : AW'($urandom_range(0, 511));
         b = AW'($urandom_range(0, 511));
         d = AW'($urandom_range(0, 511));
         test_copy($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 24)), a, b, d, -1);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 64'h0;
      for (int k = 0; k < 8; k++) begin
         mem[9'h100 + k] = 64'h1111_0000_0000_0000 | 64'(k);
         mem[9'h120 + k] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      end
      test_reset();
      test_copy("copy_a", 1'b1, 8, 9'h100, 9'h120, 9'h040, -1);
      test_copy("copy_b", 1'b0, 8, 9'h100, 9'h120, 9'h040, -1);
      test_copy("len0", 1'b1, 0, 9'h100, 9'h120, 9'h040, -1);
      test_copy("busy_start", 1'b1, 8, 9'h100, 9'h120, 9'h040, 3);
      test_copy("len4_a", 1'b1, 4, 9'h100, 9'h120, 9'h050, -1);
      test_copy("len4_b", 1'b0, 4, 9'h100, 9'h120, 9'h050, -1);
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
